// File: rtl/t07_mem_arbiter.sv
// Two-requester arbiter for the single external memory port: data has priority, fetch is
// protected from starvation. One issue cycle, wait for busy to fall (or time out), one ack cycle.
module t07_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        busy,
    input  logic [31:0] ext_rdata,
    output logic [1:0]  rwi,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    output logic        f_ack,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        freeze
);

    localparam int unsigned   SW         = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TOUT_MAX   = 8'(TIMEOUT);
    localparam logic [1:0]    RWI_IDLE   = 2'b00;
    localparam logic [1:0]    RWI_WRITE  = 2'b01;
    localparam logic [1:0]    RWI_READ   = 2'b10;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic          owner_d_q, owner_d_d;
    logic          we_q, we_d;
    logic          prev_busy_q;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    tout_q, tout_d, tout_inc;
    logic [1:0]    rwi_q, rwi_d;
    logic [31:0]   ext_addr_q, ext_addr_d;
    logic [31:0]   ext_wdata_q, ext_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic          any_req, grant_f, fall, tout_hit;

    assign any_req  = f_req | d_req;
    assign grant_f  = f_req & (~d_req | (starve_q >= STARVE_MAX));
    assign fall     = prev_busy_q & ~busy;
    assign tout_inc = tout_q + 8'd1;
    // tout_inc counts WAIT cycles including the current one
    assign tout_hit = (tout_inc == TOUT_MAX);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (fall || tout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and transaction context.
    always_comb begin
        owner_d_d   = owner_d_q;
        we_d        = we_q;
        starve_d    = starve_q;
        tout_d      = tout_q;
        rwi_d       = RWI_IDLE;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        rdata_d     = rdata_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                tout_d = '0;
                if (!f_req) starve_d = '0;
                if (any_req) begin
                    owner_d_d   = ~grant_f;
                    we_d        = ~grant_f & d_we;
                    ext_addr_d  = grant_f ? f_addr : d_addr;
                    ext_wdata_d = (~grant_f & d_we) ? d_wdata : '0;
                    rwi_d       = (~grant_f & d_we) ? RWI_WRITE : RWI_READ;
                    if (grant_f) begin
                        starve_d = '0;
                    end else if (f_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            StWait: begin
                tout_d = tout_inc;
                if (fall) begin
                    rdata_d = we_q ? '0 : ext_rdata;
                    f_ack_d = ~owner_d_q;
                    d_ack_d = owner_d_q;
                end else if (tout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    f_ack_d = ~owner_d_q;
                    d_ack_d = owner_d_q;
                end
            end
            StResp:  tout_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            owner_d_q   <= 1'b0;
            we_q        <= 1'b0;
            prev_busy_q <= 1'b0;
            starve_q    <= '0;
            tout_q      <= '0;
            rwi_q       <= RWI_IDLE;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            rdata_q     <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            owner_d_q   <= owner_d_d;
            we_q        <= we_d;
            prev_busy_q <= busy;
            starve_q    <= starve_d;
            tout_q      <= tout_d;
            rwi_q       <= rwi_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            rdata_q     <= rdata_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    assign rwi       = rwi_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign freeze    = (state_q != StIdle) | any_req;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Bench for t07_mem_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level model of arbitration, latency, timeout and ack data.
module tb_t07_mem_arbiter;

    localparam int unsigned STARVE = 4;
    localparam int unsigned TOUT   = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, busy = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, ext_rdata = '0;
    logic [1:0]  rwi;
    logic [31:0] ext_addr, ext_wdata, rdata;
    logic        f_ack, d_ack, err, freeze;

    always #5 clk = ~clk;

    t07_mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TOUT)) dut (
        .clk(clk), .nrst(nrst), .f_req(f_req), .f_addr(f_addr), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .busy(busy), .ext_rdata(ext_rdata), .rwi(rwi),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .f_ack(f_ack), .d_ack(d_ack),
        .rdata(rdata), .err(err), .freeze(freeze)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Model state
    int          cyc = 0, issue_cyc = 0, ack_cyc = 0, idle_from = 0, losses = 0;
    int          k_pend = 0, busy_cnt = 0, force_k = -1, f_rate = 0, d_rate = 0;
    int          f_ack_cnt = 0, d_ack_cnt = 0;
    bit          in_flight = 0, exp_owner_d = 0, exp_err = 0, seen_f = 0, seen_d = 0;
    bit          rd_fix_en = 0;
    logic [1:0]  exp_rwi = '0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0, rd_pend = '0, rd_fix = '0;
    logic [31:0] last_rdata = '0;
    bit          go_f = 0, go_d = 0, go_d_we = 0;
    logic [31:0] go_f_addr = '0, go_d_addr = '0, go_d_wdata = '0;

    // Decide the transaction the arbiter must start from the requests it sees this cycle.
    task automatic predict();
        bit win_f, we, fell;
        int k;
        win_f = f_req && (!d_req || losses >= STARVE);
        if (f_req && !win_f) losses++;
        else losses = 0;
        we          = !win_f && d_we;
        exp_owner_d = !win_f;
        exp_addr    = win_f ? f_addr : d_addr;
        exp_rwi     = we ? 2'b01 : 2'b10;
        exp_wdata   = we ? d_wdata : 32'h0;
        if (force_k >= 0) k = force_k;
        else begin
            case ($urandom_range(9))
                0:       k = 0;
                1:       k = TOUT - 1;
                2:       k = TOUT;
                default: k = $urandom_range(4, 1);
            endcase
        end
        k_pend    = k;
        rd_pend   = rd_fix_en ? rd_fix : $urandom;
        fell      = (k >= 1) && (k <= TOUT - 1);
        issue_cyc = cyc + 1;
        ack_cyc   = fell ? cyc + k + 3 : cyc + TOUT + 2;
        exp_err   = !fell;
        exp_rdata = (fell && !we) ? rd_pend : 32'h0;
        in_flight = 1;
    endtask

    task automatic step();
        bit active;
        @(negedge clk);
        cyc++;
        seen_f = f_ack;
        seen_d = d_ack;
        if (f_ack) f_ack_cnt++;
        if (d_ack) d_ack_cnt++;
        active = in_flight && (cyc >= issue_cyc);
        if (in_flight && cyc == issue_cyc) begin
            check("issue_rwi", 32'(rwi), 32'(exp_rwi));
            check("issue_wdata", ext_wdata, exp_wdata);
        end else begin
            check("rwi_idle", 32'(rwi), 0);
        end
        if (active) check("ext_addr", ext_addr, exp_addr);
        if (in_flight && cyc == ack_cyc) begin
            check("ack_f", 32'(f_ack), 32'(!exp_owner_d));
            check("ack_d", 32'(d_ack), 32'(exp_owner_d));
            check("ack_rdata", rdata, exp_rdata);
            check("ack_err", 32'(err), 32'(exp_err));
            last_rdata = exp_rdata;
            in_flight  = 0;
            idle_from  = cyc + 1;
            if (exp_owner_d) d_req = 1'b0;
            else f_req = 1'b0;
        end else begin
            check("no_ack", 32'({f_ack, d_ack}), 0);
            check("rdata_hold", rdata, last_rdata);
            check("err_idle", 32'(err), 0);
        end
        if (go_f) begin
            f_req = 1'b1; f_addr = go_f_addr; go_f = 0;
        end else if (!f_req && $urandom_range(99) < f_rate) begin
            f_req = 1'b1; f_addr = $urandom;
        end
        if (go_d) begin
            d_req = 1'b1; d_we = go_d_we; d_addr = go_d_addr; d_wdata = go_d_wdata; go_d = 0;
        end else if (!d_req && $urandom_range(99) < d_rate) begin
            d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
        end
        // Memory responder: busy pulse of k cycles after the issue cycle (k = 0: never busy)
        busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (in_flight && cyc == issue_cyc) begin
            busy_cnt  = k_pend;
            ext_rdata = rd_pend;
        end
        if (!in_flight && cyc >= idle_from && (f_req || d_req)) predict();
        #1;
        check("freeze", 32'(freeze), 32'(active || f_req || d_req));
    endtask

    task automatic wait_ack(input bit want_d, output int at_cyc);
        for (int i = 0; i < 300; i++) begin
            step();
            if (want_d ? seen_d : seen_f) begin
                at_cyc = cyc;
                return;
            end
        end
        check("wait_ack_expired", 0, 1);
        at_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rwi"}, 32'(rwi), 0);
        check({tag, "_addr"}, ext_addr, 0);
        check({tag, "_wdata"}, ext_wdata, 0);
        check({tag, "_acks"}, 32'({f_ack, d_ack}), 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int t, t0, acks0;
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1 check_reset_outputs("rst");
        check("rst_freeze", 32'(freeze), 0);
        repeat (2) step();
        nrst = 1'b1;

        // 1: minimum-latency fetch
        force_k = 1; rd_fix_en = 1; rd_fix = 32'h00A0_0093;
        go_f = 1; go_f_addr = 32'h0000_0100; t0 = cyc + 1;
        wait_ack(0, t);
        check("t1_latency", t - t0, 4);
        check("t1_rdata", rdata, 32'h00A0_0093);
        check("t1_err", 32'(err), 0);

        // 2: store returns rdata = 0
        force_k = 2;
        go_d = 1; go_d_we = 1; go_d_addr = 32'h3300_0004; go_d_wdata = 32'hDEAD_BEEF;
        wait_ack(1, t);
        check("t2_rdata", rdata, 0);
        check("t2_wdata_held", ext_wdata, 32'hDEAD_BEEF);

        // 3: simultaneous requests, data first
        force_k = 1; acks0 = f_ack_cnt;
        go_f = 1; go_f_addr = 32'h0000_0200;
        go_d = 1; go_d_we = 0; go_d_addr = 32'h0000_0300; go_d_wdata = 32'h0;
        wait_ack(1, t);
        check("t3_d_first", f_ack_cnt - acks0, 0);
        wait_ack(0, t);
        check("t3_f_second", f_ack_cnt - acks0, 1);

        // 4: fetch held against continuous data traffic
        d_rate = 100; acks0 = d_ack_cnt;
        go_f = 1; go_f_addr = 32'h0000_0400;
        wait_ack(0, t);
        check("t4_d_before_f", d_ack_cnt - acks0, STARVE);
        d_rate = 0;
        wait_ack(1, t);

        // 5: timeout, then a normal transaction
        force_k = 0; rd_fix = 32'h1234_5678;
        go_d = 1; go_d_we = 0; go_d_addr = 32'h0000_0500; t0 = cyc + 1;
        wait_ack(1, t);
        check("t5_latency", t - t0, TOUT + 2);
        check("t5_err", 32'(err), 1);
        check("t5_rdata", rdata, 0);
        force_k = 3;
        go_f = 1; go_f_addr = 32'h0000_0600;
        wait_ack(0, t);
        check("t5_after_err", 32'(err), 0);
        check("t5_after_rdata", rdata, 32'h1234_5678);

        // 6: reset during WAIT
        force_k = 0;
        go_f = 1; go_f_addr = 32'h0000_0700;
        repeat (3) step();
        check("t6_in_wait_addr", ext_addr, 32'h0000_0700);
        nrst = 1'b0;
        #1 check_reset_outputs("t6");
        f_req = 1'b0; d_req = 1'b0; busy = 1'b0; busy_cnt = 0;
        in_flight = 0; losses = 0; last_rdata = '0;
        repeat (2) step();
        nrst = 1'b1;
        idle_from = cyc;
        acks0 = f_ack_cnt + d_ack_cnt;
        repeat (6) step();
        check("t6_no_ack", f_ack_cnt + d_ack_cnt - acks0, 0);
        force_k = 1; rd_fix = 32'hCAFE_F00D;
        go_d = 1; go_d_we = 0; go_d_addr = 32'h0000_0800;
        wait_ack(1, t);
        check("t6_fresh_rdata", rdata, 32'hCAFE_F00D);

        // Random traffic
        force_k = -1; rd_fix_en = 0; f_rate = 30; d_rate = 40;
        repeat (3000) step();
        f_rate = 0; d_rate = 0;
        for (int i = 0; i < 500 && (in_flight || f_req || d_req); i++) step();
        check("drain_done", 32'(in_flight || f_req || d_req), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
